// File: rtl/sc_speed_scheduler.sv
// Purpose: speed scheduler FSM (IDLE/RUN/PAUSE) emitting a periodic active-low tick,
//          period LIMIT[level]+1 cycles, with four selectable speed levels.
// Latency: all outputs registered; effects of inputs appear one clock after the sampling edge.
// Backpressure: none; pause freezes the counter, stop returns to IDLE at level 0.
// Ports:
//   SC_SPEED_SCHEDULER_CLOCK_50        sole clock, rising edge
//   SC_SPEED_SCHEDULER_RESET_InHigh    synchronous active-high reset
//   SC_SPEED_SCHEDULER_start_InHigh    IDLE -> RUN
//   SC_SPEED_SCHEDULER_stop_InHigh     RUN/PAUSE -> IDLE, level and pending cleared
//   SC_SPEED_SCHEDULER_pause_InHigh    level-sensitive hold while running
//   SC_SPEED_SCHEDULER_levelUp_InHigh  request to raise level at next terminal count
//   SC_SPEED_SCHEDULER_tick_OutLow     one-cycle low pulse at each terminal count
//   SC_SPEED_SCHEDULER_level_OutBUS    current level 0..3
//   SC_SPEED_SCHEDULER_count_OutBUS    current counter value
//   SC_SPEED_SCHEDULER_running_OutHigh high only in RUN
module sc_speed_scheduler #(
   parameter int DATAWIDTH = 24,
   parameter int LIMIT_L0  = 6666667,
   parameter int LIMIT_L1  = 5000000,
   parameter int LIMIT_L2  = 3333333,
   parameter int LIMIT_L3  = 2000000
) (
   input  logic                 SC_SPEED_SCHEDULER_CLOCK_50,
   input  logic                 SC_SPEED_SCHEDULER_RESET_InHigh,
   input  logic                 SC_SPEED_SCHEDULER_start_InHigh,
   input  logic                 SC_SPEED_SCHEDULER_stop_InHigh,
   input  logic                 SC_SPEED_SCHEDULER_pause_InHigh,
   input  logic                 SC_SPEED_SCHEDULER_levelUp_InHigh,
   output logic                 SC_SPEED_SCHEDULER_tick_OutLow,
   output logic [1:0]           SC_SPEED_SCHEDULER_level_OutBUS,
   output logic [DATAWIDTH-1:0] SC_SPEED_SCHEDULER_count_OutBUS,
   output logic                 SC_SPEED_SCHEDULER_running_OutHigh
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   localparam logic [DATAWIDTH-1:0] LIM0 = DATAWIDTH'(LIMIT_L0);
   localparam logic [DATAWIDTH-1:0] LIM1 = DATAWIDTH'(LIMIT_L1);
   localparam logic [DATAWIDTH-1:0] LIM2 = DATAWIDTH'(LIMIT_L2);
   localparam logic [DATAWIDTH-1:0] LIM3 = DATAWIDTH'(LIMIT_L3);
   localparam logic [DATAWIDTH-1:0] ONE  = DATAWIDTH'(1);

   state_t                 state, state_nxt;
   logic [DATAWIDTH-1:0]   count_q, count_nxt;
   logic [1:0]             level_q, level_nxt;
   logic                   pending_q, pending_nxt;
   logic                   tick_q, tick_nxt;
   logic                   running_q, running_nxt;
   logic [DATAWIDTH-1:0]   limit_sel;
   logic                   terminal;
   logic                   raise_req;

   always_comb begin
      limit_sel = LIM0;
      case (level_q)
         2'd0:    limit_sel = LIM0;
         2'd1:    limit_sel = LIM1;
         2'd2:    limit_sel = LIM2;
         default: limit_sel = LIM3;
      endcase
   end

   // Limits only move at terminal count, so count never passes the active
   // limit; >= is just a guard against an out-of-range count.
   assign terminal  = (count_q >= limit_sel);
   // A levelUp arriving on the terminal edge itself counts immediately.
   assign raise_req = pending_q | SC_SPEED_SCHEDULER_levelUp_InHigh;

   // Next-state and next-output logic. Priority: stop > pause > terminal > start.
   always_comb begin
      state_nxt   = state;
      count_nxt   = count_q;
      level_nxt   = level_q;
      pending_nxt = raise_req;
      tick_nxt    = 1'b1;

      if (SC_SPEED_SCHEDULER_stop_InHigh && (state != IDLE)) begin
         state_nxt   = IDLE;
         count_nxt   = '0;
         level_nxt   = 2'd0;
         pending_nxt = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (SC_SPEED_SCHEDULER_start_InHigh) begin
                  state_nxt = RUN;
               end
            end
            RUN: begin
               if (SC_SPEED_SCHEDULER_pause_InHigh) begin
                  state_nxt = PAUSE;
               end else if (terminal) begin
                  count_nxt = '0;
                  tick_nxt  = 1'b0;
                  if (raise_req) begin
                     // Saturate at level 3; the request is consumed either way.
                     if (level_q != 2'd3) begin
                        level_nxt = level_q + 2'd1;
                     end
                     pending_nxt = 1'b0;
                  end
               end else begin
                  count_nxt = count_q + ONE;
               end
            end
            PAUSE: begin
               if (!SC_SPEED_SCHEDULER_pause_InHigh) begin
                  state_nxt = RUN;
               end
            end
            default: begin
               state_nxt = IDLE;
               count_nxt = '0;
               level_nxt = 2'd0;
            end
         endcase
      end

      running_nxt = (state_nxt == RUN);
   end

   always_ff @(posedge SC_SPEED_SCHEDULER_CLOCK_50) begin
      if (SC_SPEED_SCHEDULER_RESET_InHigh) begin
         state     <= IDLE;
         count_q   <= '0;
         level_q   <= 2'd0;
         pending_q <= 1'b0;
         tick_q    <= 1'b1;
         running_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         count_q   <= count_nxt;
         level_q   <= level_nxt;
         pending_q <= pending_nxt;
         tick_q    <= tick_nxt;
         running_q <= running_nxt;
      end
   end

   assign SC_SPEED_SCHEDULER_tick_OutLow     = tick_q;
   assign SC_SPEED_SCHEDULER_level_OutBUS    = level_q;
   assign SC_SPEED_SCHEDULER_count_OutBUS    = count_q;
   assign SC_SPEED_SCHEDULER_running_OutHigh = running_q;

endmodule

// File: tb/tb_sc_speed_scheduler.sv
// Purpose: self-checking bench for sc_speed_scheduler with small limits 9/7/5/3.
// Latency: one step = one clock; inputs driven after negedge, outputs sampled at next negedge.
// Backpressure: n/a.
module tb_sc_speed_scheduler;

   localparam int DW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, start, stop, pause, lvup;
   logic          tick;
   logic [1:0]    level;
   logic [DW-1:0] count;
   logic          running;

   int compared   = 0;
   int mismatched = 0;

   sc_speed_scheduler #(
      .DATAWIDTH(DW), .LIMIT_L0(9), .LIMIT_L1(7), .LIMIT_L2(5), .LIMIT_L3(3)
   ) dut (
      .SC_SPEED_SCHEDULER_CLOCK_50       (clk),
      .SC_SPEED_SCHEDULER_RESET_InHigh   (rst),
      .SC_SPEED_SCHEDULER_start_InHigh   (start),
      .SC_SPEED_SCHEDULER_stop_InHigh    (stop),
      .SC_SPEED_SCHEDULER_pause_InHigh   (pause),
      .SC_SPEED_SCHEDULER_levelUp_InHigh (lvup),
      .SC_SPEED_SCHEDULER_tick_OutLow    (tick),
      .SC_SPEED_SCHEDULER_level_OutBUS   (level),
      .SC_SPEED_SCHEDULER_count_OutBUS   (count),
      .SC_SPEED_SCHEDULER_running_OutHigh(running)
   );

   // Reference model: mode 0 = idle, 1 = running, 2 = paused.
   int lim[4] = '{9, 7, 5, 3};
   int m_mode = 0;
   int m_cnt  = 0;
   int m_lvl  = 0;
   int m_pend = 0;
   int m_tick = 1;

   task automatic model_step(input logic r, input logic s, input logic st,
                             input logic pa, input logic l);
      if (r) begin
         m_mode = 0; m_cnt = 0; m_lvl = 0; m_pend = 0; m_tick = 1;
      end else if (st && m_mode != 0) begin
         m_mode = 0; m_cnt = 0; m_lvl = 0; m_pend = 0; m_tick = 1;
      end else begin
         m_tick = 1;
         if (m_mode == 0) begin
            if (l) m_pend = 1;
            if (s) m_mode = 1;
         end else if (m_mode == 2) begin
            if (l) m_pend = 1;
            if (!pa) m_mode = 1;
         end else if (pa) begin
            if (l) m_pend = 1;
            m_mode = 2;
         end else if (m_cnt >= lim[m_lvl]) begin
            m_cnt  = 0;
            m_tick = 0;
            if (m_pend != 0 || l) begin
               m_lvl  = (m_lvl + 1 > 3) ? 3 : m_lvl + 1;
               m_pend = 0;
            end
         end else begin
            m_cnt = m_cnt + 1;
            if (l) m_pend = 1;
         end
      end
   endtask

   task automatic check(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, ".tick"},    int'(tick),    m_tick);
      check({tag, ".level"},   int'(level),   m_lvl);
      check({tag, ".count"},   int'(count),   m_cnt);
      check({tag, ".running"}, int'(running), (m_mode == 1) ? 1 : 0);
   endtask

   // One clock: drive inputs, let the edge happen, update the model, sample at negedge.
   task automatic step(input logic r, input logic s, input logic st,
                       input logic pa, input logic l);
      rst = r; start = s; stop = st; pause = pa; lvup = l;
      @(posedge clk);
      model_step(r, s, st, pa, l);
      @(negedge clk);
      rst = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; lvup = 1'b0;
   endtask

   // Step until the tick goes low; n = steps taken. Expiry is a failure.
   task automatic run_until_tick(input string tag, output int n);
      n = 0;
      for (int i = 1; i <= 40; i++) begin
         step(0, 0, 0, 0, 0);
         if (tick == 1'b0) begin
            n = i;
            return;
         end
      end
      check({tag, ".tick_timeout"}, 0, 1);
   endtask

   typedef struct {
      logic r, s, st, pa, l;
      int   e_tick, e_level, e_count, e_run;
   } vec_t;

   vec_t vt[$];

   function automatic void add(input logic r, input logic s, input logic st,
                               input logic pa, input logic l,
                               input int et, input int el, input int ec, input int er);
      vec_t v;
      v.r = r; v.s = s; v.st = st; v.pa = pa; v.l = l;
      v.e_tick = et; v.e_level = el; v.e_count = ec; v.e_run = er;
      vt.push_back(v);
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int exp_lv[4];
      exp_lv = '{1, 2, 3, 3};
      rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; lvup = 1'b0;

      // Directed table: reset, ignored inputs in IDLE, level 0 period, levelUp at count 4.
      add(1, 0, 0, 0, 0, 1, 0, 0, 0);
      add(0, 0, 0, 0, 0, 1, 0, 0, 0);
      add(0, 0, 0, 1, 0, 1, 0, 0, 0);          // pause in IDLE ignored
      add(0, 0, 1, 0, 0, 1, 0, 0, 0);          // stop in IDLE ignored
      add(0, 1, 0, 0, 0, 1, 0, 0, 1);          // start -> RUN, count 0
      add(0, 0, 0, 0, 0, 1, 0, 1, 1);
      add(0, 1, 0, 0, 0, 1, 0, 2, 1);          // start in RUN ignored
      add(0, 0, 0, 0, 0, 1, 0, 3, 1);
      add(0, 0, 0, 0, 0, 1, 0, 4, 1);
      add(0, 0, 0, 0, 1, 1, 0, 5, 1);          // levelUp seen at count 4
      for (int c = 6; c <= 9; c++) add(0, 0, 0, 0, 0, 1, 0, c, 1);
      add(0, 0, 0, 0, 0, 0, 1, 0, 1);          // terminal: tick low, level 1
      for (int c = 1; c <= 7; c++) add(0, 0, 0, 0, 0, 1, 1, c, 1);
      add(0, 0, 0, 0, 0, 0, 1, 0, 1);          // period 8 at level 1
      add(0, 0, 0, 1, 0, 1, 1, 0, 0);          // pause
      add(0, 0, 1, 0, 0, 1, 0, 0, 0);          // stop from PAUSE

      @(negedge clk);
      for (int i = 0; i < vt.size(); i++) begin
         step(vt[i].r, vt[i].s, vt[i].st, vt[i].pa, vt[i].l);
         check($sformatf("vec%0d.tick", i),    int'(tick),    vt[i].e_tick);
         check($sformatf("vec%0d.level", i),   int'(level),   vt[i].e_level);
         check($sformatf("vec%0d.count", i),   int'(count),   vt[i].e_count);
         check($sformatf("vec%0d.running", i), int'(running), vt[i].e_run);
      end

      // Pause for 5 cycles at count 6, then resume and reach terminal.
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      repeat (6) step(0, 0, 0, 0, 0);
      check("pause.pre_count", int'(count), 6);
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 0, 1, 0);
         check("pause.hold_count", int'(count), 6);
         check("pause.hold_tick", int'(tick), 1);
         check("pause.hold_running", int'(running), 0);
      end
      step(0, 0, 0, 0, 0);
      check("pause.resume_running", int'(running), 1);
      check("pause.resume_count", int'(count), 6);
      repeat (3) step(0, 0, 0, 0, 0);
      check("pause.count9", int'(count), 9);
      step(0, 0, 0, 0, 0);
      check("pause.tick", int'(tick), 0);
      check_model("pause.model");

      // Four level-up pulses across ticks: levels 1,2,3,3 then period 4.
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      for (int k = 0; k < 4; k++) begin
         step(0, 0, 0, 0, 1);
         run_until_tick("lvl", n);
         check($sformatf("lvl.level%0d", k), int'(level), exp_lv[k]);
      end
      run_until_tick("lvl.period", n);
      check("lvl.period4", n, 4);
      check("lvl.sat_level", int'(level), 3);

      // Stop+pause at level 2 mid-count with a pending request.
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      run_until_tick("stp", n);
      step(0, 0, 0, 0, 1);
      run_until_tick("stp", n);
      check("stp.level2", int'(level), 2);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      step(0, 0, 1, 1, 0);
      check("stp.tick", int'(tick), 1);
      check("stp.level", int'(level), 0);
      check("stp.count", int'(count), 0);
      check("stp.running", int'(running), 0);
      step(0, 1, 0, 0, 0);
      run_until_tick("stp", n);
      check("stp.pending_dropped", int'(level), 0);
      check("stp.period10", n, 10);

      // Reset on the edge where tick would go low, with levelUp high.
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      for (int i = 0; i < 20 && count != 9; i++) step(0, 0, 0, 0, 0);
      check("rst.pre_count", int'(count), 9);
      step(1, 0, 0, 0, 1);
      check("rst.tick", int'(tick), 1);
      check("rst.level", int'(level), 0);
      check("rst.count", int'(count), 0);
      check("rst.running", int'(running), 0);
      step(0, 0, 0, 0, 0);
      check("rst.stay_idle", int'(running), 0);
      step(0, 1, 0, 0, 0);
      run_until_tick("rst", n);
      check("rst.level_after", int'(level), 0);
      check("rst.period10", n, 10);

      // Randomized traffic against the model.
      step(1, 0, 0, 0, 0);
      begin
         logic p_hold;
         p_hold = 1'b0;
         for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) p_hold = ~p_hold;
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 59) == 0),
                 p_hold,
                 ($urandom_range(0, 14) == 0));
            check_model($sformatf("rnd%0d", i));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
